br_fifo_shared_push_ctrl_bitmap_alloc: RTL and testbench
========================================================

Name: br_fifo_shared_push_ctrl_bitmap_alloc

Overview:
Push-side controller for the shared multi-FIFO. It is the write-side counterpart of the shared pop controller. It accepts pushes from NumWritePorts ports, each tagged with a destination FIFO id, and allocates a free entry from an internal bitmap freelist. It writes the data RAM and emits per-port enqueue notifications to the linked-list pointer managers. Entries return to the freelist through the per-FIFO dealloc interface driven by the pop controller.

Parameters:
NumWritePorts, 1, number of push ports; must be >=1.
NumFifos, 2, number of logical FIFOs; must be >=2.
Depth, 8, total shared entries; must be >NumWritePorts.
Width, 8, data width; must be >=1.
RegisterWrites, 1, if 1 the RAM write and enq outputs are registered (one cycle of latency); if 0 they are combinational from the push handshake.
FifoIdWidth (localparam), $clog2(NumFifos).
AddrWidth (localparam), $clog2(Depth).
CountWidth (localparam), $clog2(Depth+1).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
push_valid  in  NumWritePorts  per-port push request
push_ready  out  NumWritePorts  per-port accept
push_data  in  NumWritePorts*Width  push payload
push_fifo_id  in  NumWritePorts*FifoIdWidth  destination FIFO
dealloc_valid  in  NumFifos  entry freed by pop side
dealloc_entry_id  in  NumFifos*AddrWidth  freed entry
data_ram_wr_valid  out  NumWritePorts  RAM write enable
data_ram_wr_addr  out  NumWritePorts*AddrWidth  RAM write address
data_ram_wr_data  out  NumWritePorts*Width  RAM write data
enq_valid  out  NumWritePorts  entry appended to a FIFO tail
enq_fifo_id  out  NumWritePorts*FifoIdWidth  target FIFO
enq_entry_id  out  NumWritePorts*AddrWidth  allocated entry
free_count  out  CountWidth  registered count of free entries
full  out  1  free_count == 0

Behaviour:
- Reset: bitmap all free; free_count = Depth; full = 0. data_ram_wr_valid, enq_valid and push_ready are 0 while rst is asserted. Registered data and address outputs reset to 0.
- Rank: rank[w] = popcount(push_valid[w-1:0]).
- Ready: push_ready[w] = (rank[w] < free_count). Ready may depend on lower ports' valid. Ports never block each other beyond this capacity rule.
- Allocation: an accepted port w takes the rank[w]-th lowest-index free entry from the bitmap as of the start of the cycle. Allocated ids are distinct within a cycle. The bitmap bit clears at the clock edge.
- Write and enqueue: on accept, the port drives data_ram_wr and enq with the allocated id, push_data and push_fifo_id.
  - Latency is 0 cycles when RegisterWrites=0 and 1 cycle when RegisterWrites=1.
  - The wr and enq outputs for a port are always coincident.
- Dealloc: each dealloc_valid[f] sets the bitmap bit at the next edge. Freed entries are allocatable from the following cycle; there is no same-cycle bypass.
- Count update: free_count_next = free_count − accepted + deallocated.
  - Computed at CountWidth+1 bits.
  - Must never underflow or exceed Depth (implementation assertions).
- Simultaneous events:
  - Alloc and dealloc in the same cycle are legal and affect different entries.
  - Several deallocs in the same cycle must carry distinct ids.
- Integration assertions:
  - Dealloc of an already-free entry.
  - push_fifo_id >= NumFifos.
  - push_valid drop or payload change while not ready.
- Reset mid-operation: pending registered writes are discarded and the bitmap returns to all-free. Downstream pointer state must be reset together with this block.

Decomposition:
- No shared package; the widths above are localparams.
- One sub-module, br_fifo_shared_bitmap_freelist. It holds the bitmap, free_count, the multi-dealloc set logic and the N-way lowest-free selection (iterated find-first-set with masking).
- The top level keeps the rank/ready logic, the alloc port mapping and the optional output registers.

Test Plan:
1. Reset, then a single push on port0 with fifo_id=1 and data=0xA5 (RegisterWrites=1) -> one cycle later wr_valid[0]=1, addr=0, data=0xA5, enq_fifo_id=1, enq_entry_id=0; free_count goes 8->7.
2. NumWritePorts=2, both ports valid every cycle until full -> ids 0..7 allocated in pairs {0,1},{2,3},...; after 4 cycles full=1 and push_ready=00.
3. Full with free_count=0, dealloc entry 5 in cycle N -> push_ready[0]=1 in cycle N+1 (not N); the next allocated id is 5.
4. free_count=1 with both ports valid -> push_ready=01. With only port1 valid -> push_ready=10 and port1 gets the single free entry.
5. Same cycle: accept 2 pushes and dealloc 3 entries from different FIFOs -> free_count changes by +1; the bitmap matches the reference model.
6. Assert rst with registered writes in flight -> wr_valid and enq_valid go 0 immediately (async reset); after release free_count=Depth and the first allocation is id 0.

Source files
------------

// File: rtl/br_fifo_shared_bitmap_freelist.sv
// Bitmap freelist for the shared multi-FIFO: one bit per entry (1 = free),
// N-way lowest-free selection for allocation and multi-port dealloc.
module br_fifo_shared_bitmap_freelist #(
  parameter  int NumAllocPorts   = 1,
  parameter  int NumDeallocPorts = 2,
  parameter  int Depth           = 8,
  localparam int AddrWidth       = $clog2(Depth),
  localparam int CountWidth      = $clog2(Depth + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NumAllocPorts-1:0]             alloc_take,
  output logic [NumAllocPorts*AddrWidth-1:0]   alloc_entry_id,
  input  logic [NumDeallocPorts-1:0]           dealloc_valid,
  input  logic [NumDeallocPorts*AddrWidth-1:0] dealloc_entry_id,
  output logic [CountWidth-1:0]                free_count,
  output logic                                 full
);

  logic [Depth-1:0]                           bitmap;
  logic [Depth-1:0]                           bitmap_next;
  logic [Depth-1:0]                           avail;
  logic [NumAllocPorts-1:0][AddrWidth-1:0]    cand;
  logic [NumDeallocPorts-1:0][AddrWidth-1:0]  dl_id;
  logic [CountWidth:0]                        n_take;
  logic [CountWidth:0]                        n_dealloc;
  logic [CountWidth:0]                        count_next;

  function automatic logic [AddrWidth-1:0] lowest_set(input logic [Depth-1:0] v);
    lowest_set = '0;
    for (int unsigned i = Depth; i > 0; i--) begin
      if (v[i-1]) lowest_set = AddrWidth'(i - 1);
    end
  endfunction

  assign dl_id          = dealloc_entry_id;
  assign alloc_entry_id = cand;

  // Candidate k is the k-th lowest free entry: find-first-set, mask it, repeat.
  always_comb begin
    avail = bitmap;
    cand  = '0;
    for (int unsigned k = 0; k < NumAllocPorts; k++) begin
      cand[k]        = lowest_set(avail);
      avail[cand[k]] = 1'b0;
    end
  end

  always_comb begin
    bitmap_next = bitmap;
    n_take      = '0;
    n_dealloc   = '0;
    for (int unsigned k = 0; k < NumAllocPorts; k++) begin
      if (alloc_take[k]) begin
        bitmap_next[cand[k]] = 1'b0;
        n_take               = n_take + (CountWidth+1)'(1);
      end
    end
    for (int unsigned f = 0; f < NumDeallocPorts; f++) begin
      if (dealloc_valid[f]) begin
        bitmap_next[dl_id[f]] = 1'b1;
        n_dealloc             = n_dealloc + (CountWidth+1)'(1);
      end
    end
    count_next = {1'b0, free_count} - n_take + n_dealloc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap     <= '1;
      free_count <= CountWidth'(Depth);
    end else begin
      bitmap     <= bitmap_next;
      free_count <= count_next[CountWidth-1:0];
    end
  end

  assign full = (free_count == '0);

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    n_take <= {1'b0, free_count});
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    count_next <= (CountWidth+1)'(Depth));

  for (genvar k = 0; k < NumAllocPorts; k++) begin : g_take_chk
    a_take_free: assert property (@(posedge clk) disable iff (rst)
      alloc_take[k] |-> bitmap[cand[k]]);
  end

  for (genvar f = 0; f < NumDeallocPorts; f++) begin : g_dealloc_chk
    a_dealloc_busy: assert property (@(posedge clk) disable iff (rst)
      dealloc_valid[f] |-> !bitmap[dl_id[f]]);
    for (genvar g = f + 1; g < NumDeallocPorts; g++) begin : g_pair
      a_dealloc_distinct: assert property (@(posedge clk) disable iff (rst)
        (dealloc_valid[f] && dealloc_valid[g]) |-> (dl_id[f] != dl_id[g]));
    end
  end

endmodule

// File: rtl/br_fifo_shared_push_ctrl_bitmap_alloc.sv
// Push-side controller of the shared multi-FIFO: ranks the push ports, allocates
// entries from the bitmap freelist and issues RAM writes plus enqueue notifications.
module br_fifo_shared_push_ctrl_bitmap_alloc #(
  parameter  int NumWritePorts  = 1,
  parameter  int NumFifos       = 2,
  parameter  int Depth          = 8,
  parameter  int Width          = 8,
  parameter  int RegisterWrites = 1,
  localparam int FifoIdWidth    = $clog2(NumFifos),
  localparam int AddrWidth      = $clog2(Depth),
  localparam int CountWidth     = $clog2(Depth + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NumWritePorts-1:0]             push_valid,
  output logic [NumWritePorts-1:0]             push_ready,
  input  logic [NumWritePorts*Width-1:0]       push_data,
  input  logic [NumWritePorts*FifoIdWidth-1:0] push_fifo_id,
  input  logic [NumFifos-1:0]                  dealloc_valid,
  input  logic [NumFifos*AddrWidth-1:0]        dealloc_entry_id,
  output logic [NumWritePorts-1:0]             data_ram_wr_valid,
  output logic [NumWritePorts*AddrWidth-1:0]   data_ram_wr_addr,
  output logic [NumWritePorts*Width-1:0]       data_ram_wr_data,
  output logic [NumWritePorts-1:0]             enq_valid,
  output logic [NumWritePorts*FifoIdWidth-1:0] enq_fifo_id,
  output logic [NumWritePorts*AddrWidth-1:0]   enq_entry_id,
  output logic [CountWidth-1:0]                free_count,
  output logic                                 full
);

  logic [NumWritePorts-1:0][CountWidth-1:0] rank;
  logic [CountWidth-1:0]                    valid_below;
  logic [NumWritePorts-1:0]                 accept;
  logic [NumWritePorts-1:0]                 slot_take;
  logic [NumWritePorts-1:0][AddrWidth-1:0]  slot_id;
  logic [NumWritePorts-1:0][AddrWidth-1:0]  alloc_id;

  always_comb begin
    valid_below = '0;
    rank        = '0;
    for (int unsigned w = 0; w < NumWritePorts; w++) begin
      rank[w]     = valid_below;
      valid_below = valid_below + CountWidth'(push_valid[w]);
    end
  end

  // Valid ports get consecutive ranks, so the accepted ones fill slots 0..n-1.
  always_comb begin
    push_ready = '0;
    for (int unsigned w = 0; w < NumWritePorts; w++) begin
      push_ready[w] = !rst && push_valid[w] && (rank[w] < free_count);
    end
  end

  assign accept = push_valid & push_ready;

  always_comb begin
    slot_take = '0;
    alloc_id  = '0;
    for (int unsigned w = 0; w < NumWritePorts; w++) begin
      for (int unsigned k = 0; k < NumWritePorts; k++) begin
        if (rank[w] == CountWidth'(k)) begin
          alloc_id[w] = slot_id[k];
          if (accept[w]) slot_take[k] = 1'b1;
        end
      end
    end
  end

  br_fifo_shared_bitmap_freelist #(
    .NumAllocPorts   (NumWritePorts),
    .NumDeallocPorts (NumFifos),
    .Depth           (Depth)
  ) u_freelist (
    .clk              (clk),
    .rst              (rst),
    .alloc_take       (slot_take),
    .alloc_entry_id   (slot_id),
    .dealloc_valid    (dealloc_valid),
    .dealloc_entry_id (dealloc_entry_id),
    .free_count       (free_count),
    .full             (full)
  );

  if (RegisterWrites != 0) begin : g_reg_out
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_ram_wr_valid <= '0;
        data_ram_wr_addr  <= '0;
        data_ram_wr_data  <= '0;
        enq_valid         <= '0;
        enq_fifo_id       <= '0;
        enq_entry_id      <= '0;
      end else begin
        data_ram_wr_valid <= accept;
        data_ram_wr_addr  <= alloc_id;
        data_ram_wr_data  <= push_data;
        enq_valid         <= accept;
        enq_fifo_id       <= push_fifo_id;
        enq_entry_id      <= alloc_id;
      end
    end
  end else begin : g_comb_out
    assign data_ram_wr_valid = accept;
    assign data_ram_wr_addr  = alloc_id;
    assign data_ram_wr_data  = push_data;
    assign enq_valid         = accept;
    assign enq_fifo_id       = push_fifo_id;
    assign enq_entry_id      = alloc_id;
  end

  logic [(1<<FifoIdWidth)-1:0] fifo_id_ok;

  always_comb begin
    fifo_id_ok = '0;
    for (int unsigned i = 0; i < (1 << FifoIdWidth); i++) begin
      fifo_id_ok[i] = (i < unsigned'(NumFifos));
    end
  end

  for (genvar w = 0; w < NumWritePorts; w++) begin : g_port_chk
    a_fifo_id_range: assert property (@(posedge clk) disable iff (rst)
      push_valid[w] |-> fifo_id_ok[push_fifo_id[w*FifoIdWidth +: FifoIdWidth]]);
    a_push_hold: assert property (@(posedge clk) disable iff (rst)
      (push_valid[w] && !push_ready[w]) |=>
        (push_valid[w] && $stable(push_data[w*Width +: Width])
                       && $stable(push_fifo_id[w*FifoIdWidth +: FifoIdWidth])));
  end

endmodule

// File: tb/tb_br_fifo_shared_push_ctrl_bitmap_alloc.sv
// Directed bench: a registered-output and a combinational-output controller
// driven with identical stimulus, expected values computed by hand.
module tb_br_fifo_shared_push_ctrl_bitmap_alloc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  push_valid;
  logic [15:0] push_data;
  logic [3:0]  push_fifo_id;
  logic [3:0]  dealloc_valid;
  logic [11:0] dealloc_entry_id;

  logic [1:0]  push_ready, wr_valid, enq_valid;
  logic [5:0]  wr_addr, enq_eid;
  logic [15:0] wr_data;
  logic [3:0]  enq_fid, free_count;
  logic        full;

  logic [1:0]  c_push_ready, c_wr_valid, c_enq_valid;
  logic [5:0]  c_wr_addr, c_enq_eid;
  logic [15:0] c_wr_data;
  logic [3:0]  c_enq_fid, c_free_count;
  logic        c_full;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  br_fifo_shared_push_ctrl_bitmap_alloc #(
    .NumWritePorts(2), .NumFifos(4), .Depth(8), .Width(8), .RegisterWrites(1)
  ) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_data(push_data), .push_fifo_id(push_fifo_id),
    .dealloc_valid(dealloc_valid), .dealloc_entry_id(dealloc_entry_id),
    .data_ram_wr_valid(wr_valid), .data_ram_wr_addr(wr_addr), .data_ram_wr_data(wr_data),
    .enq_valid(enq_valid), .enq_fifo_id(enq_fid), .enq_entry_id(enq_eid),
    .free_count(free_count), .full(full)
  );

  br_fifo_shared_push_ctrl_bitmap_alloc #(
    .NumWritePorts(2), .NumFifos(4), .Depth(8), .Width(8), .RegisterWrites(0)
  ) dut_comb (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(c_push_ready),
    .push_data(push_data), .push_fifo_id(push_fifo_id),
    .dealloc_valid(dealloc_valid), .dealloc_entry_id(dealloc_entry_id),
    .data_ram_wr_valid(c_wr_valid), .data_ram_wr_addr(c_wr_addr), .data_ram_wr_data(c_wr_data),
    .enq_valid(c_enq_valid), .enq_fifo_id(c_enq_fid), .enq_entry_id(c_enq_eid),
    .free_count(c_free_count), .full(c_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic dealloc(input logic [3:0] v, input logic [2:0] e0, input logic [2:0] e1,
                         input logic [2:0] e2, input logic [2:0] e3);
    dealloc_valid    = v;
    dealloc_entry_id = {e3, e2, e1, e0};
  endtask

  initial begin
    rst          = 1'b1;
    push_valid   = 2'b01;
    push_data    = 16'h00A5;
    push_fifo_id = 4'b0001;
    dealloc(4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    tick();

    // Reset state, with a push already pending on port 0
    check("rst_free_count", free_count, 8);
    check("rst_full", full, 0);
    check("rst_ready", push_ready, 2'b00);
    check("rst_wr_valid", wr_valid, 2'b00);
    check("rst_enq_valid", enq_valid, 2'b00);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_comb_wr_valid", c_wr_valid, 2'b00);

    // Single push, fifo 1, data A5
    rst = 1'b0;
    settle();
    check("t1_ready", push_ready, 2'b01);
    check("t1_comb_wr_valid", c_wr_valid, 2'b01);
    check("t1_comb_addr", c_wr_addr[2:0], 0);
    check("t1_comb_data", c_wr_data[7:0], 8'hA5);
    check("t1_comb_enq_eid", c_enq_eid[2:0], 0);
    check("t1_comb_enq_fid", c_enq_fid[1:0], 1);
    check("t1_reg_not_yet", wr_valid, 2'b00);
    tick();
    check("t1_wr_valid", wr_valid, 2'b01);
    check("t1_enq_valid", enq_valid, 2'b01);
    check("t1_wr_addr", wr_addr[2:0], 0);
    check("t1_wr_data", wr_data[7:0], 8'hA5);
    check("t1_enq_fid", enq_fid[1:0], 1);
    check("t1_enq_eid", enq_eid[2:0], 0);
    check("t1_free_count", free_count, 7);
    push_valid = 2'b00;
    dealloc(4'b0010, 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    check("t1_wr_pulse", wr_valid, 2'b00);
    check("t1_comb_free_count", c_free_count, 8);
    dealloc(4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);

    // Both ports every cycle until full: pairs {0,1},{2,3},{4,5},{6,7}
    push_valid   = 2'b11;
    push_fifo_id = {2'd3, 2'd2};
    for (int unsigned k = 0; k < 4; k++) begin
      push_data = {8'(8'h11 + 2*k), 8'(8'h10 + 2*k)};
      settle();
      check("t2_ready", push_ready, 2'b11);
      check("t2_comb_p0_addr", c_wr_addr[2:0], 2*k);
      check("t2_comb_p1_addr", c_wr_addr[5:3], 2*k + 1);
      tick();
      check("t2_p0_addr", wr_addr[2:0], 2*k);
      check("t2_p1_addr", wr_addr[5:3], 2*k + 1);
      check("t2_p1_data", wr_data[15:8], 8'(8'h11 + 2*k));
      check("t2_free_count", free_count, 6 - 2*k);
    end
    check("t2_full", full, 1);
    check("t2_comb_full", c_full, 1);
    check("t2_ready_full", push_ready, 2'b00);

    // Dealloc entry 5 while full: ready only from the next cycle
    dealloc(4'b0100, 3'd0, 3'd0, 3'd5, 3'd0);
    settle();
    check("t3_ready_same_cycle", push_ready, 2'b00);
    tick();
    dealloc(4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
    check("t3_wr_idle_full", wr_valid, 2'b00);
    check("t3_free_count", free_count, 1);
    check("t3_ready_next", push_ready, 2'b01);
    check("t3_comb_addr", c_wr_addr[2:0], 5);
    tick();
    check("t3_wr_valid", wr_valid, 2'b01);
    check("t3_wr_addr", wr_addr[2:0], 5);
    check("t3_wr_data", wr_data[7:0], 8'h16);
    check("t3_enq_fid", enq_fid[1:0], 2);
    check("t3_enq_eid", enq_eid[2:0], 5);

    // One free entry: both valid -> port 0 wins; port 1 alone -> port 1 takes it
    push_valid   = 2'b11;
    push_data    = {8'h17, 8'h33};
    push_fifo_id = {2'd3, 2'd0};
    dealloc(4'b0001, 3'd2, 3'd0, 3'd0, 3'd0);
    settle();
    check("t4_ready_empty", push_ready, 2'b00);
    tick();
    dealloc(4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
    check("t4_ready_both", push_ready, 2'b01);
    check("t4_comb_addr0", c_wr_addr[2:0], 2);
    tick();
    check("t4_p0_addr", wr_addr[2:0], 2);
    check("t4_p0_data", wr_data[7:0], 8'h33);
    push_valid = 2'b10;
    dealloc(4'b1000, 3'd0, 3'd0, 3'd0, 3'd6);
    settle();
    check("t4_ready_wait", push_ready, 2'b00);
    tick();
    dealloc(4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
    check("t4_ready_p1", push_ready, 2'b10);
    check("t4_comb_wr_valid", c_wr_valid, 2'b10);
    check("t4_comb_addr1", c_wr_addr[5:3], 6);
    tick();
    check("t4_wr_valid", wr_valid, 2'b10);
    check("t4_p1_addr", wr_addr[5:3], 6);
    check("t4_p1_data", wr_data[15:8], 8'h17);
    check("t4_enq_fid", enq_fid[3:2], 3);
    check("t4_full", full, 1);
    push_valid = 2'b00;

    // Two pushes and three deallocs in one cycle
    dealloc(4'b0011, 3'd0, 3'd1, 3'd0, 3'd0);
    tick();
    check("t5_free_pre", free_count, 2);
    push_valid   = 2'b11;
    push_data    = {8'h55, 8'h44};
    push_fifo_id = {2'd1, 2'd0};
    dealloc(4'b1101, 3'd3, 3'd0, 3'd4, 3'd7);
    settle();
    check("t5_ready", push_ready, 2'b11);
    check("t5_comb_addr0", c_wr_addr[2:0], 0);
    check("t5_comb_addr1", c_wr_addr[5:3], 1);
    tick();
    dealloc(4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
    check("t5_free_count", free_count, 3);
    check("t5_enq_eid1", enq_eid[5:3], 1);
    check("t5_enq_fid1", enq_fid[3:2], 1);
    push_data = {8'h77, 8'h66};
    settle();
    check("t5_bm_addr0", c_wr_addr[2:0], 3);
    check("t5_bm_addr1", c_wr_addr[5:3], 4);
    tick();
    check("t5_free_after", free_count, 1);
    push_valid   = 2'b01;
    push_data    = {8'h00, 8'h88};
    push_fifo_id = {2'd0, 2'd2};
    settle();
    check("t5_bm_last", c_wr_addr[2:0], 7);
    tick();
    check("t5_full", full, 1);
    push_valid = 2'b00;

    // Reset with a registered write in flight
    dealloc(4'b0001, 3'd3, 3'd0, 3'd0, 3'd0);
    tick();
    dealloc(4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
    push_valid   = 2'b01;
    push_data    = {8'h00, 8'h99};
    push_fifo_id = {2'd0, 2'd1};
    tick();
    check("t6_inflight", wr_valid, 2'b01);
    check("t6_inflight_addr", wr_addr[2:0], 3);
    #2;
    rst        = 1'b1;
    push_valid = 2'b00;
    #1;
    check("t6_async_wr_valid", wr_valid, 2'b00);
    check("t6_async_enq_valid", enq_valid, 2'b00);
    check("t6_async_free", free_count, 8);
    tick();
    rst          = 1'b0;
    push_valid   = 2'b01;
    push_data    = {8'h00, 8'hAB};
    push_fifo_id = {2'd0, 2'd3};
    settle();
    check("t6_free_after", free_count, 8);
    check("t6_comb_addr", c_wr_addr[2:0], 0);
    tick();
    check("t6_wr_addr", wr_addr[2:0], 0);
    check("t6_wr_data", wr_data[7:0], 8'hAB);
    check("t6_enq_fid", enq_fid[1:0], 3);
    check("t6_free_count", free_count, 7);
    push_valid = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
